// File: rtl/int_ctrl.sv
// int_ctrl: 64-source pending/priority interrupt controller with a 32-bit CPU register port.
// Define INT_CTRL_EDGE_EN for rising-edge source detection; the default build is level-sensitive.
module int_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [31:0] data_io,
  input  logic [1:0]  addr,
  input  logic        cs_en,
  input  logic        wt_en,
  input  logic        rd_en,
  input  logic [63:0] irq_in,
  input  logic [63:0] int_en,
  output logic        int_req,
  output logic [5:0]  int_id,
  input  logic        int_ack
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PEND_LO = 2'd0;
  localparam logic [1:0] ADDR_PEND_HI = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  state_t      r_state;
  logic        r_int_req;
  logic [5:0]  r_int_id;
  logic [63:0] r_pend;

  logic [63:0] w_event;
  logic [63:0] w_masked;
  logic [63:0] w_w1c;
  logic [63:0] w_ack_clr;
  logic [5:0]  w_lowest;
  logic        w_wr;
  logic        w_rd_drive;
  logic        w_eoi;
  logic        w_ack_taken;
  logic [7:0]  w_status;
  logic [31:0] w_rdata;

  assign w_wr        = cs_en & wt_en;
  assign w_rd_drive  = rst_n & cs_en & rd_en & ~wt_en;
  assign w_eoi       = w_wr && (addr == ADDR_STATUS) && (r_state == ST_SERVICE);
  assign w_ack_taken = (r_state == ST_REQ) && int_ack;

`ifdef INT_CTRL_EDGE_EN
  logic [63:0] r_irq_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_hist <= '0;
    else        r_irq_hist <= irq_in;
  end

  assign w_event = irq_in & ~r_irq_hist;
`else
  assign w_event = irq_in;
`endif

  always_comb begin
    w_w1c = '0;
    if (w_wr) begin
      case (addr)
        ADDR_PEND_LO: w_w1c[31:0]  = data_io;
        ADDR_PEND_HI: w_w1c[63:32] = data_io;
        default:      w_w1c        = '0;
      endcase
    end
  end

  assign w_ack_clr = w_ack_taken ? (64'd1 << r_int_id) : 64'd0;

  // Clears are applied first so a same-cycle source event always survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | w_event;
  end

  assign w_masked = r_pend & int_en;

  always_comb begin
    w_lowest = '0;
    for (int i = 63; i >= 0; i--) begin
      if (w_masked[i]) w_lowest = 6'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_int_req <= 1'b0;
      r_int_id  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_masked) begin
            r_state   <= ST_REQ;
            r_int_req <= 1'b1;
            r_int_id  <= w_lowest;
          end
        end
        ST_REQ: begin
          if (w_ack_taken) begin
            r_state   <= ST_SERVICE;
            r_int_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          // Dropping the id at EOI lets STATUS read all-zero once the controller is idle.
          if (w_eoi) begin
            r_state  <= ST_IDLE;
            r_int_id <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_int_req <= 1'b0;
          r_int_id  <= '0;
        end
      endcase
    end
  end

  assign w_status = {(r_state == ST_SERVICE), (r_state == ST_REQ), r_int_id};

  always_comb begin
    w_rdata = '0;
    case (addr)
      ADDR_PEND_LO: w_rdata = r_pend[31:0];
      ADDR_PEND_HI: w_rdata = r_pend[63:32];
      ADDR_STATUS:  w_rdata = {24'd0, w_status};
      default:      w_rdata = '0;
    endcase
  end

  assign data_io = w_rd_drive ? w_rdata : 32'hzzzz_zzzz;
  assign int_req = r_int_req;
  assign int_id  = r_int_id;

endmodule
